// File: rtl/wav_sel_ctrl.sv
// Waveform selector: debounced "next" button, queued presses, and click-free
// switching at the next upward midscale crossing, or after a tick timeout.
module wav_sel_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DB_W            = 20,
  parameter int ZC_TIMEOUT      = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_inc,
  input  logic       sample_tick,
  input  logic [7:0] sine_in,
  input  logic [7:0] triangle_in,
  input  logic [7:0] square_in,
  output logic [7:0] wav,
  output logic [1:0] sel,
  output logic       busy,
  output logic [1:0] pending
);

  localparam logic [7:0]      MID     = 8'd128;
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]      TO_LAST = 8'(ZC_TIMEOUT - 1);

  typedef enum logic {IDLE, ARMED} state_t;

  state_t          state_q, state_d;
  logic            sync1_q, sync2_q;
  logic            db_level_q, db_level_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic [1:0]      pending_q, pending_d;
  logic [1:0]      sel_q, sel_d;
  logic [7:0]      wav_q, wav_d;
  logic [7:0]      prev_q, prev_d;
  logic [7:0]      to_cnt_q, to_cnt_d;
  logic            press, done;
  logic [7:0]      cur, nxt_smp;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      state_q    <= IDLE;
      pending_q  <= 2'd0;
      sel_q      <= 2'd0;
      wav_q      <= MID;
      prev_q     <= MID;
      to_cnt_q   <= 8'd0;
    end else begin
      sync1_q    <= btn_inc;
      sync2_q    <= sync1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      state_q    <= state_d;
      pending_q  <= pending_d;
      sel_q      <= sel_d;
      wav_q      <= wav_d;
      prev_q     <= prev_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  // Debouncer; press fires on the same edge the level rises.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    press      = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == DB_LAST) begin
        db_level_d = ~db_level_q;
        press      = ~db_level_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (sel_q)
      2'd1:    cur = triangle_in;
      2'd2:    cur = square_in;
      default: cur = sine_in;
    endcase
    case (sel_d)
      2'd1:    nxt_smp = triangle_in;
      2'd2:    nxt_smp = square_in;
      default: nxt_smp = sine_in;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    wav_d    = wav_q;
    prev_d   = prev_q;
    to_cnt_d = to_cnt_q;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pending_q != 2'd0) begin
          state_d  = ARMED;
          to_cnt_d = 8'd0;
        end
      end
      ARMED: begin
        if (sample_tick) begin
          if (((prev_q < MID) && (cur >= MID)) || (to_cnt_q == TO_LAST)) begin
            done     = 1'b1;
            sel_d    = (sel_q == 2'd2) ? 2'd0 : sel_q + 2'd1;
            to_cnt_d = 8'd0;
            state_d  = (pending_q != 2'd1) ? ARMED : IDLE;
          end else begin
            to_cnt_d = to_cnt_q + 8'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // On a switching tick the new waveform's sample goes straight out.
    if (sample_tick) begin
      wav_d  = done ? nxt_smp : cur;
      prev_d = wav_d;
    end
  end

  // A press coinciding with a completion stays queued for its own switch.
  always_comb begin
    pending_d = pending_q;
    if (press && !done && pending_q != 2'd3) pending_d = pending_q + 2'd1;
    else if (done && !press)                 pending_d = pending_q - 2'd1;
  end

  assign wav     = wav_q;
  assign sel     = sel_q;
  assign pending = pending_q;
  assign busy    = (state_q == ARMED) || (pending_q != 2'd0);

endmodule
